// File: rtl/systolic_array_2x2_if.sv
// rtl/systolic_array_2x2_if.sv - control, operand and observation bundle for the 2x2 systolic multiplier
interface systolic_array_2x2_if #(
    parameter int W = 8
);
    logic         start;
    logic         step;
    logic [W-1:0] a11, a12, a21, a22;
    logic [W-1:0] b11, b12, b21, b22;
    logic [W-1:0] pe11, pe12, pe21, pe22;
    logic [W-1:0] sa11, sa12, sa21, sa22;
    logic [W-1:0] ct11, ct12, ct21, ct22;
    logic [2:0]   beat;
    logic         busy;
    logic         done;

    modport master (
        output start, step,
        output a11, a12, a21, a22, b11, b12, b21, b22,
        input  pe11, pe12, pe21, pe22,
        input  sa11, sa12, sa21, sa22,
        input  ct11, ct12, ct21, ct22,
        input  beat, busy, done
    );

    modport slave (
        input  start, step,
        input  a11, a12, a21, a22, b11, b12, b21, b22,
        output pe11, pe12, pe21, pe22,
        output sa11, sa12, sa21, sa22,
        output ct11, ct12, ct21, ct22,
        output beat, busy, done
    );
endinterface

// File: rtl/systolic_array_2x2.sv
// rtl/systolic_array_2x2.sv - output-stationary 2x2 systolic multiplier, one beat per step; SYSTOLIC_AUTO_STEP_EN enables the internal step divider
module systolic_array_2x2 #(
    parameter int W        = 8,
    parameter int STEP_DIV = 100000000
) (
    input  logic                  clock_100Mhz,
    input  logic                  reset,
    systolic_array_2x2_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] opa_q [4];
    logic [W-1:0] opa_d [4];
    logic [W-1:0] opb_q [4];
    logic [W-1:0] opb_d [4];
    logic [W-1:0] pe_q  [4];
    logic [W-1:0] pe_d  [4];
    logic [W-1:0] sa_q  [4];
    logic [W-1:0] sa_d  [4];
    logic [W-1:0] b_q   [4];
    logic [W-1:0] b_d   [4];
    logic [W-1:0] ct_q  [4];
    logic [W-1:0] ct_d  [4];
    logic [2:0]   beat_q, beat_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         step_fire;
    logic [W-1:0] feed_a [2];
    logic [W-1:0] feed_b [2];
    logic [W-1:0] a_in, b_in;

    if (STEP_DIV < 1) begin : g_step_div_invalid
        $error("STEP_DIV must be at least 1");
    end

`ifdef SYSTOLIC_AUTO_STEP_EN
    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    logic [DIV_W-1:0] div_q, div_d;

    // Divider only counts in RUN, so it is already clear when a new run starts.
    always_comb begin
        div_d     = '0;
        step_fire = 1'b0;
        if (state_q == RUN) begin
            if (div_q == DIV_W'(STEP_DIV - 1)) begin
                step_fire = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end
`else
    assign step_fire = bus.step;
`endif

    // Skewed edge feeds: row i lags by i beats, column j lags by j beats.
    always_comb begin
        feed_a[0] = '0;
        feed_a[1] = '0;
        feed_b[0] = '0;
        feed_b[1] = '0;
        case (beat_q)
            3'd0: begin
                feed_a[0] = opa_q[0];
                feed_b[0] = opb_q[0];
            end
            3'd1: begin
                feed_a[0] = opa_q[1];
                feed_a[1] = opa_q[2];
                feed_b[0] = opb_q[2];
                feed_b[1] = opb_q[1];
            end
            3'd2: begin
                feed_a[1] = opa_q[3];
                feed_b[1] = opb_q[3];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        busy_d  = busy_q;
        done_d  = done_q;
        a_in    = '0;
        b_in    = '0;
        for (int k = 0; k < 4; k++) begin
            opa_d[k] = opa_q[k];
            opb_d[k] = opb_q[k];
            pe_d[k]  = pe_q[k];
            sa_d[k]  = sa_q[k];
            b_d[k]   = b_q[k];
            ct_d[k]  = ct_q[k];
        end

        case (state_q)
            RUN: begin
                if (step_fire) begin
                    for (int i = 0; i < 2; i++) begin
                        for (int j = 0; j < 2; j++) begin
                            a_in = (j == 0) ? feed_a[i] : sa_q[2*i + j - 1];
                            b_in = (i == 0) ? feed_b[j] : b_q[j];
                            pe_d[2*i + j] = pe_q[2*i + j] + a_in * b_in;
                            sa_d[2*i + j] = a_in;
                            b_d[2*i + j]  = b_in;
                            if (beat_q == 3'(i + j) || beat_q == 3'(i + j + 1)) begin
                                ct_d[2*i + j] = ct_q[2*i + j] + 1'b1;
                            end
                        end
                    end
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd3) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                // Start wins over a simultaneous step; operands freeze for the run.
                if (bus.start) begin
                    opa_d   = '{bus.a11, bus.a12, bus.a21, bus.a22};
                    opb_d   = '{bus.b11, bus.b12, bus.b21, bus.b22};
                    for (int k = 0; k < 4; k++) begin
                        pe_d[k] = '0;
                        sa_d[k] = '0;
                        b_d[k]  = '0;
                        ct_d[k] = '0;
                    end
                    beat_d  = 3'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                pe_q[k]  <= '0;
                sa_q[k]  <= '0;
                b_q[k]   <= '0;
                ct_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int k = 0; k < 4; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                pe_q[k]  <= pe_d[k];
                sa_q[k]  <= sa_d[k];
                b_q[k]   <= b_d[k];
                ct_q[k]  <= ct_d[k];
            end
        end
    end

    assign bus.pe11 = pe_q[0];
    assign bus.pe12 = pe_q[1];
    assign bus.pe21 = pe_q[2];
    assign bus.pe22 = pe_q[3];
    assign bus.sa11 = sa_q[0];
    assign bus.sa12 = sa_q[1];
    assign bus.sa21 = sa_q[2];
    assign bus.sa22 = sa_q[3];
    assign bus.ct11 = ct_q[0];
    assign bus.ct12 = ct_q[1];
    assign bus.ct21 = ct_q[2];
    assign bus.ct22 = ct_q[3];
    assign bus.beat = beat_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
